dpy_scan_paged: RTL and testbench
=================================

# dpy_scan_paged

Parametrised multi-page seven-segment scanner, successor to the single-word `dpy_scan`. It holds `PAGE_CNT` debug words of `DIGIT_CNT` hex digits each and time-multiplexes one page onto the digit/segment pins. Page selection is manual, auto-rotating, or stepped by a button. It adds leading-zero blanking and tear-free frame latching. It sits in `mod_top` between the `_o_test` debug buses and the `dpy_digit`/`dpy_segment` pins.

## Interface
- `DIGIT_CNT`, 8: digits per page (1..16)
- `PAGE_CNT`, 4: number of pages (1..16)
- `SCAN_DIV`, 100_000: clocks each digit stays lit (1 ms at 100 MHz)
- `DWELL_DIV`, 200_000_000: clocks per page in auto mode (2 s at 100 MHz)
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `number`  in  PAGE_CNT*DIGIT_CNT*4  packed pages; page p, digit d = bits [(p*DIGIT_CNT+d)*4 +: 4]; digit 0 is least significant
- `dp`  in  PAGE_CNT*DIGIT_CNT  decimal points, same indexing as digits
- `mode`  in  2  00 manual, 01 auto-rotate, 10 step, 11 blank
- `page_sel`  in  PW=$clog2(PAGE_CNT) (min 1)  page used in manual mode
- `next_page`  in  1  level input (debounced button); its rising edge advances the page in step mode
- `lz_blank`  in  1  enables leading-zero blanking
- `digit_o`  out  DIGIT_CNT  one-hot digit enable, active-high
- `segment_o`  out  8  bit0..6 = segments a..g, bit7 = dp, active-high
- `page_o`  out  PW  page currently shown

## Operation
- **Scan counter** `scan_cnt`: counts 0..SCAN_DIV-1 and wraps.
  - On each wrap, digit index `idx` advances 0→DIGIT_CNT-1, then wraps to 0.
  - Both counters run in every mode, including blank.
- **Page register** `page`:
  - Manual: `page` = `page_sel`, clamped to PAGE_CNT-1 if out of range.
  - Auto: `dwell_cnt` counts 0..DWELL_DIV-1. On its wrap, `page` increments, wrapping PAGE_CNT-1→0.
  - Step: a registered rising-edge detect on `next_page` increments `page` with the same wrap.
  - Blank: `page` holds.
- **Mode changes**: any change of `mode`, sampled registered, clears `dwell_cnt` that cycle. If an edge and a mode change coincide, the mode change wins and no increment occurs.
- **Frame latch**: the selected page's nibbles and dps are copied into `frame` when `idx` wraps to 0 (the scan wrap at idx=DIGIT_CNT-1), and on the first clock after reset. `page_o` updates at the same instant.
  - Page changes and input changes mid-frame never appear until the next frame.
- **Leading-zero blanking**: when `lz_blank`=1, digit d≥1 is blanked if its nibble and all higher nibbles of `frame` are 0. Digit 0 is never blanked. A blanked digit drives segments a..g = 0 but still shows its dp.
- **Decode**: standard hex font 0..F via `hex7seg`.
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- **Mode 11 (blank)**: `digit_o`=0 and `segment_o`=0 from the next clock on.
- **Reset**: all counters 0, `page`=0, `frame`=0, `digit_o`=0, `segment_o`=0, `page_o`=0, edge-detect register 0.

## Timing
- `digit_o` and `segment_o` are registered: they reflect `idx`/`frame` one clock after `idx` changes.
- First lit digit: 2 clocks after reset deasserts. Cycle 1 latches the frame; cycle 2 drives digit 0.
- Each digit is lit exactly SCAN_DIV clocks. Frame period = DIGIT_CNT*SCAN_DIV clocks.
- Auto page period = DWELL_DIV clocks; the displayed change lands at the next frame boundary.
- Step: the increment is 1 clock after the rising edge is sampled. A held-high `next_page` gives only one increment.
- Widths: `scan_cnt` $clog2(SCAN_DIV); `dwell_cnt` $clog2(DWELL_DIV); `idx` $clog2(DIGIT_CNT) (min 1). No overflow beyond the wrap points.
- Asserting reset mid-frame forces all outputs to their reset values immediately (asynchronous).

## Structure
- Package `dpy_pkg`: `mode_e` enum (MODE_MANUAL, MODE_AUTO, MODE_STEP, MODE_BLANK) and the 16-entry segment font constant.
- Sub-module `hex7seg`: combinational nibble → 7-bit pattern, using the `dpy_pkg` font.
- The top block holds the counters, page logic, frame latch, blanking and output registers.

## Test plan
All scenarios use DIGIT_CNT=4, PAGE_CNT=3, SCAN_DIV=4, DWELL_DIV=40.
1. Reset, then manual page 1 with `number` page1=16'h12AF and `lz_blank`=0 -> `digit_o` cycles 0001,0010,0100,1000 at 4 clocks each; `segment_o` = 0x71, 0x77, 0x5B, 0x06; `page_o`=1.
2. Page0=16'h0050, `lz_blank`=1 -> digits 3,2 have segments 0x00, digit 1 = 0x6D, digit 0 = 0x3F. Page0=0 -> only digit 0 is lit (0x3F).
3. Auto mode -> `page_o` goes 0→1→2→0, each change at the first frame boundary after every 40 clocks. Switching to manual mid-dwell then back restarts the 40-clock dwell.
4. Step mode, `next_page` held high for 50 clocks -> exactly one increment. Edge coincident with a mode change -> no increment.
5. Change `number` mid-frame -> displayed digits unchanged until `idx` wraps to 0. `page_sel`=3 (out of range) -> page 2 is shown.
6. Mode 11 -> `digit_o`=0 and `segment_o`=0 the next clock. Reset asserted mid-frame -> all outputs 0 asynchronously, first digit 2 clocks after release.

Source files
------------

// File: rtl/dpy_pkg.sv
// Shared types and the seven-segment font for the paged display scanner.
// Segment bit order is a..g in bits 0..6, active-high.
package dpy_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_STEP   = 2'b10,
    MODE_BLANK  = 2'b11
  } mode_e;

  localparam logic [6:0] SEG_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/dpy_scan_paged_hex7seg.sv
// Hex nibble to seven-segment pattern lookup.
// Purely combinational, no backpressure.
module hex7seg
  import dpy_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_FONT[nibble_i];

endmodule

// File: rtl/dpy_scan_paged.sv
// Multi-page seven-segment scanner with manual/auto/step page selection.
// Outputs registered one clock behind the digit index; no backpressure.
module dpy_scan_paged
  import dpy_pkg::*;
#(
  parameter int DIGIT_CNT = 8,
  parameter int PAGE_CNT  = 4,
  parameter int SCAN_DIV  = 100_000,
  parameter int DWELL_DIV = 200_000_000,
  localparam int PW = (PAGE_CNT > 1) ? $clog2(PAGE_CNT) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [PAGE_CNT*DIGIT_CNT*4-1:0] number,
  input  logic [PAGE_CNT*DIGIT_CNT-1:0]   dp,
  input  logic [1:0]                      mode,
  input  logic [PW-1:0]                   page_sel,
  input  logic                            next_page,
  input  logic                            lz_blank,
  output logic [DIGIT_CNT-1:0]            digit_o,
  output logic [7:0]                      segment_o,
  output logic [PW-1:0]                   page_o
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DWELL_DIV > 1) ? $clog2(DWELL_DIV) : 1;
  localparam int IW = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;
  localparam int FW = DIGIT_CNT * 4;
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGIT_CNT - 1);
  localparam logic [PW-1:0] PAGE_MAX  = PW'(PAGE_CNT - 1);

  logic [SW-1:0]        scan_q, scan_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [PW-1:0]        page_q, page_d, page_inc;
  logic [PW-1:0]        pout_q;
  logic [1:0]           mode_q;
  logic                 np_q, rise_q, started_q;
  logic [FW-1:0]        frame_q, page_nib, hi_nib;
  logic [DIGIT_CNT-1:0] frame_dp_q, page_dp;
  logic [DIGIT_CNT-1:0] digit_q, digit_d;
  logic [7:0]           seg_q, seg_d;
  logic [3:0]           cur_nib;
  logic [6:0]           font_seg;
  logic                 scan_wrap, mode_chg, latch, lead_zero;
  mode_e                mode_cur;

  assign mode_cur = mode_e'(mode);
  assign page_nib = number[page_d*FW +: FW];
  assign page_dp  = dp[page_d*DIGIT_CNT +: DIGIT_CNT];
  assign cur_nib  = frame_q[idx_q*4 +: 4];
  assign hi_nib   = frame_q >> (idx_q * 4);

  hex7seg u_font (
    .nibble_i (cur_nib),
    .seg_o    (font_seg)
  );

  always_comb begin
    scan_wrap = (scan_q == SCAN_MAX);
    mode_chg  = (mode != mode_q);
    page_inc  = (page_q == PAGE_MAX) ? '0 : page_q + 1'b1;
    scan_d    = scan_q;
    idx_d     = idx_q;
    dwell_d   = '0;
    page_d    = page_q;
    // The very first clock only latches a frame; scanning starts on the next one.
    if (started_q) begin
      scan_d = scan_wrap ? '0 : scan_q + 1'b1;
      if (scan_wrap) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    unique case (mode_cur)
      MODE_MANUAL: page_d = (page_sel > PAGE_MAX) ? PAGE_MAX : page_sel;
      MODE_AUTO: begin
        if (!mode_chg) begin
          if (dwell_q == DWELL_MAX) page_d = page_inc;
          else dwell_d = dwell_q + 1'b1;
        end
      end
      MODE_STEP: if (!mode_chg && rise_q) page_d = page_inc;
      default: ;
    endcase
    latch     = !started_q || (scan_wrap && idx_q == IDX_MAX);
    lead_zero = lz_blank && (idx_q != '0) && (hi_nib == '0);
    digit_d   = '0;
    seg_d     = '0;
    if (started_q && mode_cur != MODE_BLANK) begin
      digit_d = DIGIT_CNT'(1) << idx_q;
      seg_d   = {frame_dp_q[idx_q], lead_zero ? 7'h00 : font_seg};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_q     <= '0;
      idx_q      <= '0;
      dwell_q    <= '0;
      page_q     <= '0;
      pout_q     <= '0;
      mode_q     <= '0;
      np_q       <= 1'b0;
      rise_q     <= 1'b0;
      started_q  <= 1'b0;
      frame_q    <= '0;
      frame_dp_q <= '0;
      digit_q    <= '0;
      seg_q      <= '0;
    end else begin
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      dwell_q   <= dwell_d;
      page_q    <= page_d;
      mode_q    <= mode;
      np_q      <= next_page;
      rise_q    <= next_page & ~np_q;
      started_q <= 1'b1;
      digit_q   <= digit_d;
      seg_q     <= seg_d;
      if (latch) begin
        frame_q    <= page_nib;
        frame_dp_q <= page_dp;
        pout_q     <= page_d;
      end
    end
  end

  assign digit_o   = digit_q;
  assign segment_o = seg_q;
  assign page_o    = pout_q;

endmodule

// File: tb/tb_dpy_scan_paged.sv
// Randomized bench for dpy_scan_paged against a timing-arithmetic reference model.
module tb_dpy_scan_paged;

  localparam int DC = 4;
  localparam int PC = 3;
  localparam int SD = 4;
  localparam int DD = 40;
  localparam int PW = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [PC*DC*4-1:0] number;
  logic [PC*DC-1:0]  dp;
  logic [1:0]        mode;
  logic [PW-1:0]     page_sel;
  logic              next_page;
  logic              lz_blank;
  logic [DC-1:0]     digit_o;
  logic [7:0]        segment_o;
  logic [PW-1:0]     page_o;

  int n_vec = 0;
  int n_bad = 0;
  int cur   = 0;

  dpy_scan_paged #(
    .DIGIT_CNT (DC),
    .PAGE_CNT  (PC),
    .SCAN_DIV  (SD),
    .DWELL_DIV (DD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .number    (number),
    .dp        (dp),
    .mode      (mode),
    .page_sel  (page_sel),
    .next_page (next_page),
    .lz_blank  (lz_blank),
    .digit_o   (digit_o),
    .segment_o (segment_o),
    .page_o    (page_o)
  );

  always #5 clock = ~clock;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: edges since reset release, current page, shown frame.
  int         k = 0;
  int         m_page = 0;
  int         m_page_o = 0;
  int         m_age = 0;
  bit         prev_np = 0;
  bit         pend = 0;
  logic [1:0] prev_mode = 2'b00;
  logic [3:0] fr_nib [DC];
  bit         fr_dp [DC];
  logic [DC-1:0] e_dig = '0;
  logic [7:0]    e_seg = '0;

  function automatic logic [7:0] model_seg(int i);
    bit hz = 1'b1;
    for (int j = i; j < DC; j++) if (fr_nib[j] != 4'h0) hz = 1'b0;
    return {fr_dp[i], (lz_blank && i > 0 && hz) ? 7'h00 : font[fr_nib[i]]};
  endfunction

  task automatic model_reset();
    k = 0; m_page = 0; m_page_o = 0; m_age = 0;
    prev_np = 0; pend = 0; prev_mode = 2'b00;
    e_dig = '0; e_seg = '0;
    for (int d = 0; d < DC; d++) begin
      fr_nib[d] = 4'h0;
      fr_dp[d]  = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else begin
        int i_sh;
        bit chg;
        k++;
        if (k == 1 || mode == 2'b11) begin
          e_dig = '0;
          e_seg = '0;
        end else begin
          i_sh  = ((k - 2) / SD) % DC;
          e_dig = DC'(1) << i_sh;
          e_seg = model_seg(i_sh);
        end
        chg = (mode != prev_mode);
        case (mode)
          2'b00: m_page = (int'(page_sel) > PC - 1) ? PC - 1 : int'(page_sel);
          2'b01: begin
            if (chg) m_age = 0;
            else begin
              m_age++;
              if (m_age == DD) begin
                m_age  = 0;
                m_page = (m_page + 1) % PC;
              end
            end
          end
          2'b10: if (!chg && pend) m_page = (m_page + 1) % PC;
          default: ;
        endcase
        pend      = next_page && !prev_np;
        prev_np   = next_page;
        prev_mode = mode;
        if ((k - 1) % (SD * DC) == 0) begin
          m_page_o = m_page;
          for (int d = 0; d < DC; d++) begin
            fr_nib[d] = number[(m_page * DC + d) * 4 +: 4];
            fr_dp[d]  = dp[m_page * DC + d];
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] want);
    check({nm, "_dut"}, dut_v, want);
    check({nm, "_model"}, mdl_v, want);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      check("digit", 32'(digit_o), 32'(e_dig));
      check("segment", 32'(segment_o), 32'(e_seg));
      check("page", 32'(page_o), m_page_o);
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic goto_edge(input int e);
    adv(e - cur);
    cur = e;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("rst_digit", 32'(digit_o), 0);
    check("rst_segment", 32'(segment_o), 0);
    check("rst_page", 32'(page_o), 0);
    adv(2);
    reset = 1'b0;
    cur   = 0;
  endtask

  task automatic rand_number();
    for (int n = 0; n < PC * DC; n++)
      number[n*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
  endtask

  initial begin
    number = '0; dp = '0; mode = 2'b00; page_sel = '0; next_page = 1'b0; lz_blank = 1'b0;
    adv(3);

    // Manual page 1, no blanking, plus a mid-frame data change and page clamp.
    rand_number();
    number[16 +: 16] = 16'h12AF;
    page_sel = 2'd1;
    do_reset();
    goto_edge(1);  lit("t1_e1_dig", 32'(digit_o), 32'(e_dig), 0);
    goto_edge(2);  lit("t1_d0_dig", 32'(digit_o), 32'(e_dig), 1);
                   lit("t1_d0_seg", 32'(segment_o), 32'(e_seg), 8'h71);
                   lit("t1_page", 32'(page_o), m_page_o, 1);
    goto_edge(5);  lit("t1_d0_hold", 32'(digit_o), 32'(e_dig), 1);
    goto_edge(6);  lit("t1_d1_dig", 32'(digit_o), 32'(e_dig), 2);
                   lit("t1_d1_seg", 32'(segment_o), 32'(e_seg), 8'h77);
    number[16 +: 16] = 16'h3333;
    goto_edge(10); lit("t1_d2_seg", 32'(segment_o), 32'(e_seg), 8'h5B);
    goto_edge(14); lit("t1_d3_dig", 32'(digit_o), 32'(e_dig), 8);
                   lit("t1_d3_seg", 32'(segment_o), 32'(e_seg), 8'h06);
    goto_edge(17); lit("t5_old_frame", 32'(segment_o), 32'(e_seg), 8'h06);
    goto_edge(18); lit("t5_new_frame", 32'(segment_o), 32'(e_seg), 8'h4F);
    page_sel = 2'd3;
    number[32 +: 16] = 16'h0007;
    goto_edge(34); lit("t5_clamp_page", 32'(page_o), m_page_o, 2);
                   lit("t5_clamp_seg", 32'(segment_o), 32'(e_seg), 8'h07);

    // Leading-zero blanking with a dp on a blanked digit.
    number[0 +: 16] = 16'h0050;
    dp = '0; dp[3] = 1'b1;
    lz_blank = 1'b1;
    page_sel = 2'd0;
    do_reset();
    goto_edge(2);  lit("t2_d0", 32'(segment_o), 32'(e_seg), 8'h3F);
    goto_edge(6);  lit("t2_d1", 32'(segment_o), 32'(e_seg), 8'h6D);
    goto_edge(10); lit("t2_d2", 32'(segment_o), 32'(e_seg), 8'h00);
    goto_edge(14); lit("t2_d3_dp", 32'(segment_o), 32'(e_seg), 8'h80);
    number[0 +: 16] = 16'h0000;
    dp = '0;
    goto_edge(18); lit("t2_zero_d0", 32'(segment_o), 32'(e_seg), 8'h3F);
    goto_edge(22); lit("t2_zero_d1", 32'(segment_o), 32'(e_seg), 8'h00);
                   lit("t2_zero_dig", 32'(digit_o), 32'(e_dig), 2);

    // Auto rotation and dwell restart.
    lz_blank = 1'b0;
    rand_number();
    mode = 2'b01;
    do_reset();
    goto_edge(48);  lit("t3_p0", 32'(page_o), m_page_o, 0);
    goto_edge(49);  lit("t3_p1", 32'(page_o), m_page_o, 1);
    goto_edge(80);  lit("t3_p1_hold", 32'(page_o), m_page_o, 1);
    goto_edge(81);  lit("t3_p2", 32'(page_o), m_page_o, 2);
    goto_edge(128); lit("t3_p2_hold", 32'(page_o), m_page_o, 2);
    goto_edge(129); lit("t3_wrap", 32'(page_o), m_page_o, 0);
    goto_edge(140); mode = 2'b00; page_sel = 2'd0;
    goto_edge(145); mode = 2'b01;
    goto_edge(177); lit("t3_restart_hold", 32'(page_o), m_page_o, 0);
    goto_edge(193); lit("t3_restart_p1", 32'(page_o), m_page_o, 1);

    // Step mode: held button, blank mode, edge coincident with a mode change.
    mode = 2'b10;
    next_page = 1'b0;
    do_reset();
    goto_edge(3);  next_page = 1'b1;
    goto_edge(53); lit("t4_one_inc", 32'(page_o), m_page_o, 1);
                   lit("t4_lit", 32'(digit_o), 32'(e_dig), 1);
                   next_page = 1'b0; mode = 2'b11;
    goto_edge(54); lit("t6_blank_dig", 32'(digit_o), 32'(e_dig), 0);
                   lit("t6_blank_seg", 32'(segment_o), 32'(e_seg), 0);
    goto_edge(55); next_page = 1'b1;
    goto_edge(56); mode = 2'b10;
    goto_edge(65); lit("t4_coincide", 32'(page_o), m_page_o, 1);
    goto_edge(81); lit("t4_coincide2", 32'(page_o), m_page_o, 1);

    // Randomized phase with occasional mid-frame resets.
    for (int r = 0; r < 40; r++) begin
      int len;
      len      = $urandom_range(10, 200);
      mode     = 2'($urandom);
      page_sel = 2'($urandom);
      lz_blank = 1'($urandom);
      for (int c = 0; c < len; c++) begin
        adv(1);
        if ($urandom_range(0, 15) == 0) rand_number();
        if ($urandom_range(0, 15) == 0) dp = 12'($urandom);
        if ($urandom_range(0, 7) == 0) next_page = ~next_page;
        if ($urandom_range(0, 31) == 0) page_sel = 2'($urandom);
      end
      if ($urandom_range(0, 7) == 0) do_reset();
    end
    adv(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
